// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs drained round-robin onto NWP
// registered PRF write / ROB completion ports, with same-cycle flush gating.
module wb_arbiter #(
    parameter int NCH   = 4,
    parameter int NWP   = 2,
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int PRW   = 6,
    parameter int ROBW  = 5
) (
    input  logic                cpu_clock_i,
    input  logic                cpu_reset_i,
    input  logic                flush_i,
    input  logic [NCH-1:0]      ch_valid_i,
    output logic [NCH-1:0]      ch_ready_o,
    input  logic [NCH*DW-1:0]   ch_data_i,
    input  logic [NCH*PRW-1:0]  ch_dest_i,
    input  logic [NCH-1:0]      ch_wb_i,
    input  logic [NCH*ROBW-1:0] ch_rob_id_i,
    output logic [NWP*DW-1:0]   p_we_data_o,
    output logic [NWP*PRW-1:0]  p_we_dest_o,
    output logic [NWP-1:0]      p_wen_o,
    output logic [NWP*ROBW-1:0] rob_id_o,
    output logic [NWP-1:0]      rob_valid_o
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

    logic [DW-1:0]   mem_data_q [NCH][DEPTH];
    logic [PRW-1:0]  mem_dest_q [NCH][DEPTH];
    logic            mem_wb_q   [NCH][DEPTH];
    logic [ROBW-1:0] mem_rob_q  [NCH][DEPTH];

    logic [PW-1:0]   wr_ptr_q [NCH];
    logic [PW-1:0]   wr_ptr_d [NCH];
    logic [PW-1:0]   rd_ptr_q [NCH];
    logic [PW-1:0]   rd_ptr_d [NCH];
    logic [CNTW-1:0] cnt_q    [NCH];
    logic [CNTW-1:0] cnt_d    [NCH];
    logic [CW-1:0]   rr_q, rr_d;

    logic [NCH-1:0]  push, pop;
    logic [NWP-1:0]  gnt_vld;
    logic [CW-1:0]   gnt_ch [NWP];
    int              n_gnt, idx, last_ch;

    logic [NWP-1:0]      wen_q, wen_d, rv_q, rv_d;
    logic [NWP*DW-1:0]   data_q, data_d;
    logic [NWP*PRW-1:0]  dest_q, dest_d;
    logic [NWP*ROBW-1:0] rob_q, rob_d;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            ch_ready_o[c] = (cnt_q[c] != CNTW'(DEPTH));
        end
    end

    // Round-robin scan starting at rr_q; the k-th non-empty head goes to port k.
    always_comb begin
        gnt_vld = '0;
        pop     = '0;
        n_gnt   = 0;
        idx     = 0;
        last_ch = int'(rr_q);
        for (int k = 0; k < NWP; k++) begin
            gnt_ch[k] = '0;
        end
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr_q) + i) % NCH;
            if (cnt_q[idx] != '0 && n_gnt < NWP && !flush_i) begin
                gnt_vld[n_gnt] = 1'b1;
                gnt_ch[n_gnt]  = CW'(idx);
                pop[idx]       = 1'b1;
                last_ch        = idx;
                n_gnt          = n_gnt + 1;
            end
        end
        rr_d = rr_q;
        if (gnt_vld[0]) begin
            rr_d = (last_ch == NCH - 1) ? '0 : CW'(last_ch + 1);
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            push[c]     = ch_valid_i[c] && ch_ready_o[c] && !flush_i;
            wr_ptr_d[c] = wr_ptr_q[c] + PW'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
            cnt_d[c]    = cnt_q[c] + CNTW'(push[c]) - CNTW'(pop[c]);
            if (flush_i) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                cnt_d[c]    = '0;
            end
        end
    end

    // Ungranted ports keep their payload; only the valid bits are cleared.
    always_comb begin
        wen_d  = '0;
        rv_d   = '0;
        data_d = data_q;
        dest_d = dest_q;
        rob_d  = rob_q;
        for (int k = 0; k < NWP; k++) begin
            if (gnt_vld[k]) begin
                rv_d[k]                  = 1'b1;
                wen_d[k]                 = mem_wb_q[gnt_ch[k]][rd_ptr_q[gnt_ch[k]]];
                data_d[k*DW +: DW]       = mem_data_q[gnt_ch[k]][rd_ptr_q[gnt_ch[k]]];
                dest_d[k*PRW +: PRW]     = mem_dest_q[gnt_ch[k]][rd_ptr_q[gnt_ch[k]]];
                rob_d[k*ROBW +: ROBW]    = mem_rob_q[gnt_ch[k]][rd_ptr_q[gnt_ch[k]]];
            end
        end
    end

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            rr_q   <= '0;
            wen_q  <= '0;
            rv_q   <= '0;
            data_q <= '0;
            dest_q <= '0;
            rob_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            rr_q   <= rr_d;
            wen_q  <= wen_d;
            rv_q   <= rv_d;
            data_q <= data_d;
            dest_q <= dest_d;
            rob_q  <= rob_d;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) begin
                mem_data_q[c][wr_ptr_q[c]] <= ch_data_i[c*DW +: DW];
                mem_dest_q[c][wr_ptr_q[c]] <= ch_dest_i[c*PRW +: PRW];
                mem_wb_q[c][wr_ptr_q[c]]   <= ch_wb_i[c];
                mem_rob_q[c][wr_ptr_q[c]]  <= ch_rob_id_i[c*ROBW +: ROBW];
            end
        end
    end

    assign p_wen_o     = wen_q & ~{NWP{flush_i}};
    assign rob_valid_o = rv_q & ~{NWP{flush_i}};
    assign p_we_data_o = data_q;
    assign p_we_dest_o = dest_q;
    assign rob_id_o    = rob_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NCH=4, NWP=2, DEPTH=2): latency, round-robin
// order, backpressure, wb=0 completions, flush gating and async reset.
module tb_wb_arbiter;
    localparam int NCH = 4, NWP = 2, DEPTH = 2, DW = 32, PRW = 6, ROBW = 5;

    logic                clk = 1'b0;
    logic                rst, flush;
    logic [NCH-1:0]      valid, ready, wb;
    logic [NCH*DW-1:0]   data;
    logic [NCH*PRW-1:0]  dest;
    logic [NCH*ROBW-1:0] rob;
    logic [NWP*DW-1:0]   o_data;
    logic [NWP*PRW-1:0]  o_dest;
    logic [NWP-1:0]      o_wen, o_rv;
    logic [NWP*ROBW-1:0] o_rob;

    int vectors = 0;
    int miscompares = 0;

    wb_arbiter #(.NCH(NCH), .NWP(NWP), .DEPTH(DEPTH), .DW(DW), .PRW(PRW), .ROBW(ROBW)) dut (
        .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush),
        .ch_valid_i(valid), .ch_ready_o(ready), .ch_data_i(data),
        .ch_dest_i(dest), .ch_wb_i(wb), .ch_rob_id_i(rob),
        .p_we_data_o(o_data), .p_we_dest_o(o_dest), .p_wen_o(o_wen),
        .rob_id_o(o_rob), .rob_valid_o(o_rv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] d, input logic [5:0] ds,
                          input logic w, input logic [4:0] r);
        valid[c]              = 1'b1;
        data[c*DW +: DW]      = d;
        dest[c*PRW +: PRW]    = ds;
        wb[c]                 = w;
        rob[c*ROBW +: ROBW]   = r;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = '0; wb = '0; data = '0; dest = '0; rob = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_wen", 64'(o_wen), 64'h0);
        chk("rst_rv", 64'(o_rv), 64'h0);
        chk("rst_data", 64'(o_data), 64'h0);
        chk("rst_dest", 64'(o_dest), 64'h0);
        chk("rst_rob", 64'(o_rob), 64'h0);
        chk("rst_ready", 64'(ready), 64'hF);

        // single push on ch2, two-cycle latency
        set_ch(2, 32'hDEADBEEF, 6'd5, 1'b1, 5'd3);
        tick(); valid = '0;
        chk("t1_rv_early", 64'(o_rv), 64'h0);
        tick();
        chk("t1_wen", 64'(o_wen), 64'h1);
        chk("t1_rv", 64'(o_rv), 64'h1);
        chk("t1_dest", 64'(o_dest[5:0]), 64'd5);
        chk("t1_rob", 64'(o_rob[4:0]), 64'd3);
        chk("t1_data", 64'(o_data[31:0]), 64'hDEADBEEF);
        tick();
        chk("t1_idle", 64'(o_rv), 64'h0);

        // ch3 alone brings rr back to 0
        set_ch(3, 32'h33, 6'd7, 1'b1, 5'd4);
        tick(); valid = '0; tick();
        chk("rr_rob", 64'(o_rob[4:0]), 64'd4);

        // all channels at once
        for (int c = 0; c < NCH; c++) set_ch(c, 32'h100 + c, 6'(10 + c), 1'b1, 5'(20 + c));
        tick(); valid = '0;
        chk("t2_ready", 64'(ready), 64'hF);
        tick();
        chk("t2a_rv", 64'(o_rv), 64'h3);
        chk("t2a_wen", 64'(o_wen), 64'h3);
        chk("t2a_rob", 64'(o_rob), 64'({5'd21, 5'd20}));
        chk("t2a_data1", 64'(o_data[63:32]), 64'h101);
        tick();
        chk("t2b_rob", 64'(o_rob), 64'({5'd23, 5'd22}));
        chk("t2b_dest", 64'(o_dest), 64'({6'd13, 6'd12}));
        tick();
        chk("t2_idle", 64'(o_rv), 64'h0);

        // rr must be 0: ch0 ahead of ch3
        set_ch(0, 32'h1, 6'd1, 1'b1, 5'd1);
        set_ch(3, 32'h2, 6'd2, 1'b1, 5'd2);
        tick(); valid = '0; tick();
        chk("rr0_rob", 64'(o_rob), 64'({5'd2, 5'd1}));
        tick();

        // ch1 back-to-back, order preserved
        set_ch(1, 32'hA, 6'd20, 1'b1, 5'd6);
        tick();
        chk("t3_ready1", 64'(ready), 64'hF);
        set_ch(1, 32'hB, 6'd21, 1'b1, 5'd7);
        tick();
        chk("t3_outA", 64'(o_rob[4:0]), 64'd6);
        chk("t3_rvA", 64'(o_rv), 64'h1);
        set_ch(1, 32'hC, 6'd22, 1'b1, 5'd8);
        tick(); valid = '0;
        chk("t3_outB", 64'(o_rob[4:0]), 64'd7);
        tick();
        chk("t3_outC", 64'(o_rob[4:0]), 64'd8);
        chk("t3_dataC", 64'(o_data[31:0]), 64'hC);
        tick();
        chk("t3_idle", 64'(o_rv), 64'h0);

        // completion without PRF write
        set_ch(1, 32'h99, 6'd9, 1'b0, 5'd9);
        tick(); valid = '0; tick();
        chk("t4_rv", 64'(o_rv), 64'h1);
        chk("t4_wen", 64'(o_wen), 64'h0);
        chk("t4_rob", 64'(o_rob[4:0]), 64'd9);
        tick();

        // saturate all channels (rr=2), then flush
        for (int c = 0; c < NCH; c++) set_ch(c, 32'h200 + c, 6'd0, 1'b1, 5'(8 + c));
        tick();
        chk("t5_ready1", 64'(ready), 64'hF);
        for (int c = 0; c < NCH; c++) set_ch(c, 32'h300 + c, 6'd0, 1'b1, 5'(16 + c));
        tick();
        chk("t5_ready2", 64'(ready), 64'hC);
        chk("t5_rob2", 64'(o_rob), 64'({5'd11, 5'd10}));
        for (int c = 0; c < NCH; c++) set_ch(c, 32'h400 + c, 6'd0, 1'b1, 5'(24 + c));
        tick();
        chk("t5_ready3", 64'(ready), 64'h3);
        chk("t5_rob3", 64'(o_rob), 64'({5'd9, 5'd8}));
        chk("t5_rv3", 64'(o_rv), 64'h3);
        flush = 1'b1;
        #1;
        chk("t5_flush_rv", 64'(o_rv), 64'h0);
        chk("t5_flush_wen", 64'(o_wen), 64'h0);
        tick();
        flush = 1'b0; valid = '0;
        chk("t5_post_ready", 64'(ready), 64'hF);
        chk("t5_post_rv", 64'(o_rv), 64'h0);
        tick();
        chk("t5_nostale1", 64'(o_rv), 64'h0);
        tick();
        chk("t5_nostale2", 64'(o_rv), 64'h0);

        // rr retained across flush (2): ch3 precedes ch0
        set_ch(0, 32'h5, 6'd3, 1'b1, 5'd1);
        set_ch(3, 32'h6, 6'd4, 1'b1, 5'd2);
        tick(); valid = '0; tick();
        chk("t5_rr_rob", 64'(o_rob), 64'({5'd1, 5'd2}));
        tick();

        // async reset mid-burst (rr=1)
        for (int c = 0; c < NCH; c++) set_ch(c, 32'h500 + c, 6'd0, 1'b1, 5'(24 + c));
        tick(); valid = '0; tick();
        chk("t6_rv", 64'(o_rv), 64'h3);
        chk("t6_rob", 64'(o_rob), 64'({5'd26, 5'd25}));
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_rv", 64'(o_rv), 64'h0);
        chk("t6_rst_rob", 64'(o_rob), 64'h0);
        chk("t6_rst_ready", 64'(ready), 64'hF);
        #2 rst = 1'b0;
        set_ch(2, 32'hCAFEF00D, 6'd5, 1'b1, 5'd3);
        tick(); valid = '0;
        chk("t6_lat1", 64'(o_rv), 64'h0);
        tick();
        chk("t6_rv2", 64'(o_rv), 64'h1);
        chk("t6_rob2", 64'(o_rob[4:0]), 64'd3);
        chk("t6_data2", 64'(o_data[31:0]), 64'hCAFEF00D);
        tick();
        chk("t6_idle", 64'(o_rv), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
